// File: rtl/fht_stage_seq.sv
`default_nettype none
// ============================================================================
// Module   : fht_stage_seq
// Purpose  : Stage/address sequencer for an in-place FHT with mirrored
//            butterfly addressing and a delayed write-back side.
// Revision : 1.0
// ============================================================================
module fht_stage_seq #(
    parameter int A_BIT    = 8,
    parameter int SEC_BIT  = 4,
    parameter int STAGES   = A_BIT + 2,
    parameter int PIPE_LAT = 4
) (
    input  logic               iCLK,
    input  logic               iRESET,
    input  logic               iSTART,
    input  logic               iHOLD,
    output logic               oRDY,
    output logic               oDONE,
    output logic [3:0]         oSTAGE,
    output logic               oST_ZERO,
    output logic               oST_LAST,
    output logic [SEC_BIT-1:0] oSECTOR,
    output logic               o2ND_PART_SUBSECTOR,
    output logic [A_BIT-1:0]   oADDR_RD,
    output logic [A_BIT-1:0]   oADDR_RD_BIAS,
    output logic [A_BIT-1:0]   oADDR_COEF,
    output logic [A_BIT-1:0]   oADDR_WR,
    output logic [A_BIT-1:0]   oADDR_WR_BIAS,
    output logic               oWE_A,
    output logic               oWE_B
);

    localparam int               c_word_w     = 2 * A_BIT + 2;
    localparam logic [A_BIT:0]   c_cnt_last   = {(A_BIT + 1){1'b1}};
    localparam logic [3:0]       c_stage_last = 4'(STAGES - 1);
    localparam logic [3:0]       c_gap_last   = 4'(PIPE_LAT - 1);
    localparam logic [A_BIT:0]   c_one_s      = (A_BIT + 1)'(1);
    localparam logic [A_BIT-1:0] c_one_a      = A_BIT'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [A_BIT:0]   r_cnt;
    logic [A_BIT:0]   w_cnt_nxt;
    logic [3:0]       r_stage;
    logic [3:0]       w_stage_nxt;
    logic [3:0]       r_gap;
    logic [3:0]       w_gap_nxt;

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_stage <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_stage <= w_stage_nxt;
            r_gap   <= w_gap_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stage_nxt = r_stage;
        w_gap_nxt   = r_gap;
        if (!iHOLD) begin
            case (r_state)
                ST_IDLE: begin
                    if (iSTART) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = '0;
                        w_stage_nxt = '0;
                        w_gap_nxt   = '0;
                    end
                end
                ST_RUN: begin
                    if (r_cnt == c_cnt_last) begin
                        w_state_nxt = ST_GAP;
                        w_cnt_nxt   = '0;
                        w_gap_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    // GAP lasts PIPE_LAT cycles so the write tail drains before the next read
                    if (r_gap == c_gap_last) begin
                        w_gap_nxt = '0;
                        if (r_stage == c_stage_last) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_state_nxt = ST_RUN;
                            w_stage_nxt = r_stage + 1'b1;
                            w_cnt_nxt   = '0;
                        end
                    end else begin
                        w_gap_nxt = r_gap + 1'b1;
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                    w_stage_nxt = '0;
                    w_cnt_nxt   = '0;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    logic             w_run;
    logic [A_BIT-1:0] w_p;
    logic             w_h;
    logic [3:0]       w_s_eff;
    logic [A_BIT:0]   w_span;
    logic [A_BIT-1:0] w_mask;
    logic [A_BIT-1:0] w_half;
    logic [A_BIT-1:0] w_sub;
    logic [A_BIT-1:0] w_base;
    logic [A_BIT-1:0] w_bias;
    logic [A_BIT-1:0] w_coef;

    assign w_run   = (r_state == ST_RUN);
    assign w_p     = r_cnt[A_BIT:1];
    assign w_h     = r_cnt[0];
    assign w_s_eff = (int'(r_stage) < A_BIT) ? r_stage : 4'(A_BIT);

    // span = 2^s'; mask selects the position inside the current subsector
    assign w_span  = c_one_s << w_s_eff;
    assign w_mask  = A_BIT'(w_span - c_one_s);
    assign w_half  = A_BIT'(w_span >> 1);
    assign w_sub   = w_p & w_mask;
    assign w_base  = w_p & ~w_mask;
    assign w_bias  = w_base | ((~w_sub + c_one_a) & w_mask);
    assign w_coef  = w_sub << (A_BIT - int'(w_s_eff));

    always_comb begin
        oADDR_RD            = '0;
        oADDR_RD_BIAS       = '0;
        oADDR_COEF          = '0;
        oSECTOR             = '0;
        o2ND_PART_SUBSECTOR = 1'b0;
        if (w_run) begin
            oADDR_RD            = w_p;
            oADDR_RD_BIAS       = w_bias;
            oADDR_COEF          = w_coef;
            oSECTOR             = SEC_BIT'(w_p >> w_s_eff);
            o2ND_PART_SUBSECTOR = |(w_sub & w_half);
        end
    end

    logic [c_word_w-1:0] w_rd_word;
    logic [c_word_w-1:0] w_wr_word;
    logic [c_word_w-1:0] r_pipe [PIPE_LAT];

    assign w_rd_word = {w_run & ~w_h, w_run & w_h, oADDR_RD, oADDR_RD_BIAS};

    // Write side trails the read side by PIPE_LAT non-held cycles
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_pipe[i] <= '0;
            end
        end else if (!iHOLD) begin
            r_pipe[0] <= w_rd_word;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign w_wr_word     = r_pipe[PIPE_LAT-1];
    assign oWE_A         = w_wr_word[c_word_w-1] & ~iHOLD;
    assign oWE_B         = w_wr_word[c_word_w-2] & ~iHOLD;
    assign oADDR_WR      = w_wr_word[2*A_BIT-1:A_BIT];
    assign oADDR_WR_BIAS = w_wr_word[A_BIT-1:0];

    assign oRDY     = (r_state == ST_IDLE);
    assign oDONE    = (r_state == ST_DONE) & ~iHOLD;
    assign oSTAGE   = r_stage;
    assign oST_ZERO = ((r_state == ST_RUN) || (r_state == ST_GAP)) && (r_stage == 4'd0);
    assign oST_LAST = ((r_state == ST_RUN) || (r_state == ST_GAP)) && (r_stage == c_stage_last);

endmodule
`default_nettype wire
